hazard_forward_scheduler: RTL and testbench
===========================================

Name: hazard_forward_scheduler

Overview:
- Pipeline hazard scheduler for the RV32IM 5-stage core; sits in ID stage beside the register file.
- Compares ID-stage source registers against EX- and MEM-stage destinations; registers the 2-bit MEM/WB forward-enable codes consumed by the EX-stage forwarding unit (bit0 = operand1, bit1 = operand2).
- Inserts the one-cycle load-use stall.
- Sequences multi-cycle M-extension ops by freezing the front end for a programmable latency.

Parameters:
- MUL_LATENCY, 2, total EX-occupancy cycles for MUL/MULH/MULHSU/MULHU (>=1)
- DIV_LATENCY, 33, total EX-occupancy cycles for DIV/DIVU/REM/REMU (>=1)
- CNT_W, 6, cycle counter width; must hold max(MUL_LATENCY, DIV_LATENCY)

Ports:
- CLK  in  1  core clock
- RESET  in  1  asynchronous, active-low reset
- ID_RS1, ID_RS2  in  5 each  ID-stage source register addresses
- ID_RS1_USED, ID_RS2_USED  in  1 each  ID instruction reads rs1/rs2
- EX_RD  in  5  EX-stage destination
- EX_WE  in  1  EX instruction writes the register file
- EX_MEMREAD  in  1  EX instruction is a load
- EX_MUL_START, EX_DIV_START  in  1 each  M-ext op entered EX this cycle
- MEM_RD  in  5  MEM-stage destination
- MEM_WE  in  1  MEM instruction writes the register file
- FLUSH  in  1  taken branch/jump resolved in EX
- MEM_FORWARD_EN  out  2  registered forward-from-MEM code for the instruction entering EX
- WB_FORWARD_EN  out  2  registered forward-from-WB code for the instruction entering EX
- PC_HOLD, IFID_HOLD  out  1 each  freeze PC / IF-ID register
- IDEX_HOLD  out  1  freeze ID-EX register
- IDEX_BUBBLE  out  1  load NOP into ID-EX
- EXMEM_BUBBLE  out  1  load NOP into EX-MEM
- MULDIV_DONE  out  1  one-cycle pulse: M-ext result valid in EX this cycle

Behaviour:
- Reset (RESET=0, async): all outputs 0, FSM=IDLE, counter=0.
- Match rules:
  - matchEX_n = ID_RSn_USED && EX_WE && EX_RD!=0 && EX_RD==ID_RSn.
  - matchMEM_n = ID_RSn_USED && MEM_WE && MEM_RD!=0 && MEM_RD==ID_RSn.
- Forward codes, registered on the posedge where ID advances into EX:
  - MEM_FORWARD_EN[n-1] <= matchEX_n && !EX_MEMREAD.
  - WB_FORWARD_EN[n-1] <= matchMEM_n.
  - MEM and WB bits may both be 1; the forwarding unit gives MEM priority.
  - Latency: 1 cycle, compare in ID to use in EX.
- Load-use (IDLE only):
  - Condition: EX_MEMREAD && (matchEX_1 || matchEX_2).
  - Response, combinational, for exactly 1 cycle: PC_HOLD=IFID_HOLD=IDEX_BUBBLE=1.
  - Forward codes register as 00/00 that cycle. Next cycle the load is in MEM, rematch yields the WB code.
- FLUSH: IDEX_BUBBLE=1, forward codes register 00/00, load-use stall suppressed (FLUSH wins).
- FSM states: IDLE, BUSY, DONE.
  - IDLE->BUSY on EX_DIV_START (lat=DIV_LATENCY), else on EX_MUL_START (lat=MUL_LATENCY). DIV wins if both are set.
  - If lat==1: IDLE->DONE directly, no stall.
  - Counter loads 1 in the start cycle; start cycle is combinationally stalled.
  - BUSY: counter increments each cycle. PC_HOLD=IFID_HOLD=IDEX_HOLD=EXMEM_BUBBLE=1 while counter<lat.
  - When counter==lat-1, next state DONE.
  - DONE (1 cycle): MULDIV_DONE=1, all holds 0, EX result proceeds to MEM. Then DONE->IDLE; same-cycle new EX start is legal and re-enters BUSY.
  - Stall cycles = lat-1.
- During BUSY/DONE: forward outputs hold their value (operands already captured). Load-use and FLUSH are ignored in BUSY.
- Load-use coincident with a start: M-ext freeze dominates; load-use re-evaluated after DONE.
- Reset mid-BUSY: immediate return to IDLE, holds drop asynchronously.

Test Plan:
- EX: add x5 (WE=1); ID: sub rs1=x5, rs2=x6 -> next cycle MEM_FORWARD_EN=01, WB_FORWARD_EN=00.
- MEM: x7 writer, EX: x7 writer, ID rs2=x7 -> MEM_FORWARD_EN=10 and WB_FORWARD_EN=10. Repeat with rd=x0 -> both 00.
- EX lw x3, ID rs1=x3 -> PC_HOLD/IFID_HOLD/IDEX_BUBBLE high exactly 1 cycle, then WB_FORWARD_EN=01. Same with FLUSH=1 -> no stall, codes 00.
- EX_DIV_START with DIV_LATENCY=33 -> holds high 32 consecutive cycles, MULDIV_DONE pulses cycle 33. MUL with latency 2 -> 1 stall cycle. Latency 1 -> 0 stalls, DONE next cycle.
- EX_MUL_START and EX_DIV_START together -> DIV latency used. Back-to-back DIV start in DONE cycle -> re-enters BUSY with no idle gap.
- RESET low at BUSY counter=10 -> all outputs 0 asynchronously; after release, FSM IDLE, no MULDIV_DONE.

Source files
------------

// File: rtl/hazard_forward_scheduler_if.sv
// rtl/hazard_forward_scheduler_if.sv - ID-stage hazard/forward scheduler pipeline interface
//
// Groups every pipeline-facing signal of hazard_forward_scheduler.
//   master : pipeline side (drives stage register fields, receives holds/bubbles/forward codes)
//   slave  : scheduler side
// Signal summary:
//   ID_RS1/ID_RS2, ID_RS1_USED/ID_RS2_USED : ID-stage source operands and their use flags
//   EX_RD, EX_WE, EX_MEMREAD               : EX-stage destination, write enable, load flag
//   EX_MUL_START, EX_DIV_START             : M-extension op entered EX this cycle
//   MEM_RD, MEM_WE                         : MEM-stage destination and write enable
//   FLUSH                                  : taken branch/jump resolved in EX
//   MEM_FORWARD_EN, WB_FORWARD_EN          : registered forward codes (bit0 = op1, bit1 = op2)
//   PC_HOLD, IFID_HOLD, IDEX_HOLD          : front-end / ID-EX freeze
//   IDEX_BUBBLE, EXMEM_BUBBLE              : NOP injection into ID-EX / EX-MEM
//   MULDIV_DONE                            : one-cycle M-extension result-valid pulse
interface hazard_forward_scheduler_if;
    logic [4:0] ID_RS1;
    logic [4:0] ID_RS2;
    logic       ID_RS1_USED;
    logic       ID_RS2_USED;
    logic [4:0] EX_RD;
    logic       EX_WE;
    logic       EX_MEMREAD;
    logic       EX_MUL_START;
    logic       EX_DIV_START;
    logic [4:0] MEM_RD;
    logic       MEM_WE;
    logic       FLUSH;
    logic [1:0] MEM_FORWARD_EN;
    logic [1:0] WB_FORWARD_EN;
    logic       PC_HOLD;
    logic       IFID_HOLD;
    logic       IDEX_HOLD;
    logic       IDEX_BUBBLE;
    logic       EXMEM_BUBBLE;
    logic       MULDIV_DONE;

    modport master (
        output ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
        output EX_RD, EX_WE, EX_MEMREAD, EX_MUL_START, EX_DIV_START,
        output MEM_RD, MEM_WE, FLUSH,
        input  MEM_FORWARD_EN, WB_FORWARD_EN,
        input  PC_HOLD, IFID_HOLD, IDEX_HOLD, IDEX_BUBBLE, EXMEM_BUBBLE, MULDIV_DONE
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_RS1_USED, ID_RS2_USED,
        input  EX_RD, EX_WE, EX_MEMREAD, EX_MUL_START, EX_DIV_START,
        input  MEM_RD, MEM_WE, FLUSH,
        output MEM_FORWARD_EN, WB_FORWARD_EN,
        output PC_HOLD, IFID_HOLD, IDEX_HOLD, IDEX_BUBBLE, EXMEM_BUBBLE, MULDIV_DONE
    );
endinterface

// File: rtl/hazard_forward_scheduler.sv
// rtl/hazard_forward_scheduler.sv - RV32IM ID-stage hazard detection, forward-code and M-ext stall scheduler
//
// Ports:
//   CLK   : core clock
//   RESET : asynchronous active-low reset
//   hif   : hazard_forward_scheduler_if.slave (see interface file for the signal list)
// Parameters:
//   MUL_LATENCY : total EX-occupancy cycles of MUL/MULH/MULHSU/MULHU (>=1)
//   DIV_LATENCY : total EX-occupancy cycles of DIV/DIVU/REM/REMU (>=1)
//   CNT_W       : occupancy counter width, must hold max(MUL_LATENCY, DIV_LATENCY)
module hazard_forward_scheduler #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 6
) (
    input logic                       CLK,
    input logic                       RESET,
    hazard_forward_scheduler_if.slave hif
);

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [1:0]       mem_fwd_q, mem_fwd_d;
    logic [1:0]       wb_fwd_q, wb_fwd_d;

    logic             match_ex1, match_ex2;
    logic             match_mem1, match_mem2;
    logic             load_use;
    logic             mdu_start;
    logic [CNT_W-1:0] start_lat;
    logic             freeze;
    logic             lu_stall;
    logic             bubble;
    logic             done_pulse;

    // Register-address comparisons; x0 never produces a hazard.
    always_comb begin
        match_ex1  = hif.ID_RS1_USED && hif.EX_WE && (hif.EX_RD != 5'd0) && (hif.EX_RD == hif.ID_RS1);
        match_ex2  = hif.ID_RS2_USED && hif.EX_WE && (hif.EX_RD != 5'd0) && (hif.EX_RD == hif.ID_RS2);
        match_mem1 = hif.ID_RS1_USED && hif.MEM_WE && (hif.MEM_RD != 5'd0) && (hif.MEM_RD == hif.ID_RS1);
        match_mem2 = hif.ID_RS2_USED && hif.MEM_WE && (hif.MEM_RD != 5'd0) && (hif.MEM_RD == hif.ID_RS2);
        load_use   = hif.EX_MEMREAD && (match_ex1 || match_ex2);
        mdu_start  = hif.EX_DIV_START || hif.EX_MUL_START;
        // Divide takes precedence when both start strobes are set.
        start_lat  = hif.EX_DIV_START ? DIV_LAT : MUL_LAT;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        mem_fwd_d  = mem_fwd_q;
        wb_fwd_d   = wb_fwd_q;
        freeze     = 1'b0;
        lu_stall   = 1'b0;
        bubble     = 1'b0;
        done_pulse = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done_pulse = (state_q == ST_DONE);
                if (mdu_start) begin
                    // The counter is the number of occupancy cycles already spent;
                    // the start cycle itself is occupancy cycle 1.
                    lat_d = start_lat;
                    cnt_d = CNT_ONE;
                    if (start_lat <= CNT_ONE) begin
                        // Single-cycle op: result is ready next cycle, no stall.
                        state_d = ST_DONE;
                    end else begin
                        // Start cycle is stalled combinationally. A start seen in DONE
                        // chains straight into the next op, so it freezes here as well.
                        freeze  = 1'b1;
                        state_d = (CNT_ONE == (start_lat - CNT_ONE)) ? ST_DONE : ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end

                // Hazard handling only while the front end is free to advance;
                // codes do not move in DONE because operands were captured at issue.
                if ((state_q == ST_IDLE) && !freeze) begin
                    if (hif.FLUSH) begin
                        bubble    = 1'b1;
                        mem_fwd_d = 2'b00;
                        wb_fwd_d  = 2'b00;
                    end else if (load_use) begin
                        lu_stall  = 1'b1;
                        bubble    = 1'b1;
                        mem_fwd_d = 2'b00;
                        wb_fwd_d  = 2'b00;
                    end else begin
                        // A load in EX cannot forward from EX/MEM; the stall handles it.
                        mem_fwd_d = {match_ex2 && !hif.EX_MEMREAD, match_ex1 && !hif.EX_MEMREAD};
                        wb_fwd_d  = {match_mem2, match_mem1};
                    end
                end
            end

            ST_BUSY: begin
                freeze = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_d == (lat_q - CNT_ONE)) begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            mem_fwd_q <= 2'b00;
            wb_fwd_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            mem_fwd_q <= mem_fwd_d;
            wb_fwd_q  <= wb_fwd_d;
        end
    end

    // Combinational controls are gated by RESET so every output drops
    // immediately when reset asserts, whatever the stage inputs show.
    assign hif.MEM_FORWARD_EN = mem_fwd_q;
    assign hif.WB_FORWARD_EN  = wb_fwd_q;
    assign hif.PC_HOLD        = RESET && (freeze || lu_stall);
    assign hif.IFID_HOLD      = RESET && (freeze || lu_stall);
    assign hif.IDEX_HOLD      = RESET && freeze;
    assign hif.IDEX_BUBBLE    = RESET && bubble;
    assign hif.EXMEM_BUBBLE   = RESET && freeze;
    assign hif.MULDIV_DONE    = RESET && done_pulse;

endmodule

// File: tb/tb_hazard_forward_scheduler.sv
// tb/tb_hazard_forward_scheduler.sv - self-checking bench for hazard_forward_scheduler
module tb_hazard_forward_scheduler;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    hazard_forward_scheduler_if hif0 ();
    hazard_forward_scheduler_if hif1 ();

    hazard_forward_scheduler #(.MUL_LATENCY(2), .DIV_LATENCY(33), .CNT_W(6)) dut (
        .CLK(CLK), .RESET(RESET), .hif(hif0)
    );

    hazard_forward_scheduler #(.MUL_LATENCY(1), .DIV_LATENCY(3), .CNT_W(6)) dut1 (
        .CLK(CLK), .RESET(RESET), .hif(hif1)
    );

    assign hif1.ID_RS1       = hif0.ID_RS1;
    assign hif1.ID_RS2       = hif0.ID_RS2;
    assign hif1.ID_RS1_USED  = hif0.ID_RS1_USED;
    assign hif1.ID_RS2_USED  = hif0.ID_RS2_USED;
    assign hif1.EX_RD        = hif0.EX_RD;
    assign hif1.EX_WE        = hif0.EX_WE;
    assign hif1.EX_MEMREAD   = hif0.EX_MEMREAD;
    assign hif1.EX_MUL_START = hif0.EX_MUL_START;
    assign hif1.EX_DIV_START = hif0.EX_DIV_START;
    assign hif1.MEM_RD       = hif0.MEM_RD;
    assign hif1.MEM_WE       = hif0.MEM_WE;
    assign hif1.FLUSH        = hif0.FLUSH;

    logic [9:0] o0, o1;
    assign o0 = {hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, hif0.PC_HOLD, hif0.IFID_HOLD,
                 hif0.IDEX_HOLD, hif0.IDEX_BUBBLE, hif0.EXMEM_BUBBLE, hif0.MULDIV_DONE};
    assign o1 = {hif1.MEM_FORWARD_EN, hif1.WB_FORWARD_EN, hif1.PC_HOLD, hif1.IFID_HOLD,
                 hif1.IDEX_HOLD, hif1.IDEX_BUBBLE, hif1.EXMEM_BUBBLE, hif1.MULDIV_DONE};

    typedef struct packed {
        logic [1:0] mem;
        logic [1:0] wb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        hif0.ID_RS1       = 5'd0;
        hif0.ID_RS2       = 5'd0;
        hif0.ID_RS1_USED  = 1'b0;
        hif0.ID_RS2_USED  = 1'b0;
        hif0.EX_RD        = 5'd0;
        hif0.EX_WE        = 1'b0;
        hif0.EX_MEMREAD   = 1'b0;
        hif0.EX_MUL_START = 1'b0;
        hif0.EX_DIV_START = 1'b0;
        hif0.MEM_RD       = 5'd0;
        hif0.MEM_WE       = 1'b0;
        hif0.FLUSH        = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        idle_in();
        #1;
        n_checks++;
        if (o0 !== 10'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", o0, 10'd0); end
        n_checks++;
        if (o1 !== 10'd0) begin n_fail++; $display("FAIL reset_outputs_lat1: got %b expected %b", o1, 10'd0); end
        // Load-use pattern while in reset must still leave outputs low.
        hif0.EX_RD = 5'd3; hif0.EX_WE = 1'b1; hif0.EX_MEMREAD = 1'b1;
        hif0.ID_RS1 = 5'd3; hif0.ID_RS1_USED = 1'b1;
        tick();
        tick();
        n_checks++;
        if (o0 !== 10'd0) begin n_fail++; $display("FAIL reset_gated: got %b expected %b", o0, 10'd0); end
        idle_in();
        RESET = 1'b1;
        #1;
        n_checks++;
        if (o0 !== 10'd0) begin n_fail++; $display("FAIL reset_release: got %b expected %b", o0, 10'd0); end
    endtask

    task automatic test_ex_forward();
        exp_t e;
        idle_in();
        hif0.EX_RD = 5'd5; hif0.EX_WE = 1'b1;
        hif0.ID_RS1 = 5'd5; hif0.ID_RS1_USED = 1'b1;
        hif0.ID_RS2 = 5'd6; hif0.ID_RS2_USED = 1'b1;
        sb.push_back(exp_t'({2'b01, 2'b00}));
        #1;
        n_checks++;
        if (hif0.PC_HOLD !== 1'b0) begin n_fail++; $display("FAIL ex_fwd_no_stall: got %b expected 0", hif0.PC_HOLD); end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL ex_fwd: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        // Same registers, but rs1 not read: no forwarding.
        hif0.ID_RS1_USED = 1'b0;
        sb.push_back(exp_t'({2'b00, 2'b00}));
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL ex_fwd_unused: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
    endtask

    task automatic test_mem_ex_forward();
        exp_t e;
        idle_in();
        hif0.MEM_RD = 5'd7; hif0.MEM_WE = 1'b1;
        hif0.EX_RD = 5'd7; hif0.EX_WE = 1'b1;
        hif0.ID_RS1 = 5'd1; hif0.ID_RS1_USED = 1'b1;
        hif0.ID_RS2 = 5'd7; hif0.ID_RS2_USED = 1'b1;
        sb.push_back(exp_t'({2'b10, 2'b10}));
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL mem_ex_fwd: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        hif0.ID_RS1 = 5'd7;
        sb.push_back(exp_t'({2'b11, 2'b11}));
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL mem_ex_fwd_both: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        hif0.MEM_RD = 5'd0; hif0.EX_RD = 5'd0;
        hif0.ID_RS1 = 5'd0; hif0.ID_RS2 = 5'd0;
        sb.push_back(exp_t'({2'b00, 2'b00}));
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL x0_no_fwd: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        idle_in();
        hif0.EX_RD = 5'd3; hif0.EX_WE = 1'b1; hif0.EX_MEMREAD = 1'b1;
        hif0.ID_RS1 = 5'd3; hif0.ID_RS1_USED = 1'b1;
        hif0.ID_RS2 = 5'd4; hif0.ID_RS2_USED = 1'b1;
        sb.push_back(exp_t'({2'b00, 2'b00}));
        #1;
        n_checks++;
        if ({hif0.PC_HOLD, hif0.IFID_HOLD, hif0.IDEX_BUBBLE, hif0.IDEX_HOLD, hif0.EXMEM_BUBBLE} !== 5'b11100) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b expected 11100",
                     {hif0.PC_HOLD, hif0.IFID_HOLD, hif0.IDEX_BUBBLE, hif0.IDEX_HOLD, hif0.EXMEM_BUBBLE});
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL load_use_codes: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        // Load moves to MEM, bubble sits in EX.
        hif0.EX_RD = 5'd0; hif0.EX_WE = 1'b0; hif0.EX_MEMREAD = 1'b0;
        hif0.MEM_RD = 5'd3; hif0.MEM_WE = 1'b1;
        sb.push_back(exp_t'({2'b00, 2'b01}));
        #1;
        n_checks++;
        if ({hif0.PC_HOLD, hif0.IFID_HOLD, hif0.IDEX_BUBBLE} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_use_one_cycle: got %b expected 000", {hif0.PC_HOLD, hif0.IFID_HOLD, hif0.IDEX_BUBBLE});
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL load_use_wb_fwd: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        // Same load-use with FLUSH: no stall, bubble only, codes cleared.
        hif0.MEM_RD = 5'd0; hif0.MEM_WE = 1'b0;
        hif0.EX_RD = 5'd3; hif0.EX_WE = 1'b1; hif0.EX_MEMREAD = 1'b1;
        hif0.FLUSH = 1'b1;
        sb.push_back(exp_t'({2'b00, 2'b00}));
        #1;
        n_checks++;
        if ({hif0.PC_HOLD, hif0.IFID_HOLD, hif0.IDEX_BUBBLE, hif0.IDEX_HOLD, hif0.EXMEM_BUBBLE} !== 5'b00100) begin
            n_fail++;
            $display("FAIL flush_wins: got %b expected 00100",
                     {hif0.PC_HOLD, hif0.IFID_HOLD, hif0.IDEX_BUBBLE, hif0.IDEX_HOLD, hif0.EXMEM_BUBBLE});
        end
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL flush_codes: got mem=%b wb=%b expected mem=%b wb=%b", hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        idle_in();
    endtask

    task automatic test_random_forward();
        exp_t e;
        logic m1, m2, w1, w2, lu, mr;
        int   bad = 0;
        for (int i = 0; i < 24; i++) begin
            hif0.ID_RS1      = 5'($urandom_range(0, 3));
            hif0.ID_RS2      = 5'($urandom_range(0, 3));
            hif0.ID_RS1_USED = 1'($urandom_range(0, 1));
            hif0.ID_RS2_USED = 1'($urandom_range(0, 1));
            hif0.EX_RD       = 5'($urandom_range(0, 3));
            hif0.EX_WE       = 1'($urandom_range(0, 1));
            hif0.EX_MEMREAD  = 1'($urandom_range(0, 3) == 0);
            hif0.MEM_RD      = 5'($urandom_range(0, 3));
            hif0.MEM_WE      = 1'($urandom_range(0, 1));
            mr = hif0.EX_MEMREAD;
            m1 = hif0.ID_RS1_USED && hif0.EX_WE && hif0.EX_RD != 0 && hif0.EX_RD == hif0.ID_RS1;
            m2 = hif0.ID_RS2_USED && hif0.EX_WE && hif0.EX_RD != 0 && hif0.EX_RD == hif0.ID_RS2;
            w1 = hif0.ID_RS1_USED && hif0.MEM_WE && hif0.MEM_RD != 0 && hif0.MEM_RD == hif0.ID_RS1;
            w2 = hif0.ID_RS2_USED && hif0.MEM_WE && hif0.MEM_RD != 0 && hif0.MEM_RD == hif0.ID_RS2;
            lu = mr && (m1 || m2);
            sb.push_back(lu ? exp_t'(4'b0000) : exp_t'({m2 && !mr, m1 && !mr, w2, w1}));
            #1;
            if (hif0.PC_HOLD !== lu) begin
                bad++;
                $display("FAIL rand_stall[%0d]: got %b expected %b", i, hif0.PC_HOLD, lu);
            end
            tick();
            e = sb.pop_front();
            if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
                bad++;
                $display("FAIL rand_fwd[%0d]: got mem=%b wb=%b expected mem=%b wb=%b", i, hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
            end
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rand_summary: got %0d bad vectors expected 0", bad); end
        idle_in();
    endtask

    task automatic test_muldiv(input string name, input logic mul, input logic div,
                               input int exp_d0, input int exp_s0, input int exp_d1, input int exp_s1);
        exp_t e;
        int d0 = -1, d1 = -1, s0 = 0, s1 = 0, bub = 0, fwd_bad = 0, extra = 0;
        idle_in();
        hif0.EX_RD = 5'd5; hif0.EX_WE = 1'b1;
        hif0.ID_RS1 = 5'd5; hif0.ID_RS1_USED = 1'b1;
        sb.push_back(exp_t'({2'b01, 2'b00}));
        tick();
        e = sb.pop_front();
        n_checks++;
        if (hif0.MEM_FORWARD_EN !== e.mem || hif0.WB_FORWARD_EN !== e.wb) begin
            n_fail++;
            $display("FAIL %s_pre_fwd: got mem=%b wb=%b expected mem=%b wb=%b", name, hif0.MEM_FORWARD_EN, hif0.WB_FORWARD_EN, e.mem, e.wb);
        end
        idle_in();
        hif0.EX_MUL_START = mul;
        hif0.EX_DIV_START = div;
        for (int c = 0; c < 100 && (d0 < 0 || d1 < 0); c++) begin
            if (c == 1) begin
                // Load-use, MEM match and FLUSH noise that a busy unit must ignore.
                hif0.EX_MUL_START = 1'b0; hif0.EX_DIV_START = 1'b0;
                hif0.EX_RD = 5'd9; hif0.EX_WE = 1'b1; hif0.EX_MEMREAD = 1'b1;
                hif0.MEM_RD = 5'd9; hif0.MEM_WE = 1'b1;
                hif0.ID_RS2 = 5'd9; hif0.ID_RS2_USED = 1'b1;
                hif0.FLUSH = (c % 2) == 1;
            end
            #1;
            if (d0 < 0) begin
                if (hif0.MULDIV_DONE) d0 = c;
                else begin
                    if (hif0.PC_HOLD && hif0.IFID_HOLD && hif0.IDEX_HOLD && hif0.EXMEM_BUBBLE) s0++;
                    if (hif0.IDEX_BUBBLE) bub++;
                end
                if (hif0.MEM_FORWARD_EN !== 2'b01 || hif0.WB_FORWARD_EN !== 2'b00) fwd_bad++;
            end
            if (d1 < 0) begin
                if (hif1.MULDIV_DONE) d1 = c;
                else if (hif1.PC_HOLD && hif1.IFID_HOLD && hif1.IDEX_HOLD && hif1.EXMEM_BUBBLE) s1++;
            end
            tick();
        end
        n_checks++;
        if (d0 !== exp_d0 || s0 !== exp_s0) begin
            n_fail++;
            $display("FAIL %s_main: got done_cycle=%0d stalls=%0d expected done_cycle=%0d stalls=%0d", name, d0, s0, exp_d0, exp_s0);
        end
        n_checks++;
        if (d1 !== exp_d1 || s1 !== exp_s1) begin
            n_fail++;
            $display("FAIL %s_alt: got done_cycle=%0d stalls=%0d expected done_cycle=%0d stalls=%0d", name, d1, s1, exp_d1, exp_s1);
        end
        n_checks++;
        if (bub !== 0 || fwd_bad !== 0) begin
            n_fail++;
            $display("FAIL %s_busy_ignore: got bubbles=%0d fwd_changes=%0d expected 0 and 0", name, bub, fwd_bad);
        end
        idle_in();
        for (int c = 0; c < 3; c++) begin
            #1;
            if (hif0.MULDIV_DONE || hif1.MULDIV_DONE) extra++;
            tick();
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL %s_single_pulse: got %0d extra pulses expected 0", name, extra); end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        logic held = 1'b0;
        idle_in();
        hif0.EX_DIV_START = 1'b1;
        for (int c = 0; c < 200 && second < 0; c++) begin
            if (c == 1 || (first >= 0 && c == first + 1)) hif0.EX_DIV_START = 1'b0;
            #1;
            if (first >= 0 && c == first + 1) held = hif0.PC_HOLD;
            if (hif0.MULDIV_DONE) begin
                if (first < 0) begin
                    first = c;
                    hif0.EX_DIV_START = 1'b1;
                end else begin
                    second = c;
                end
            end
            tick();
        end
        n_checks++;
        if (first !== 32) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 32", first); end
        n_checks++;
        if (held !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: got hold=%b expected 1", held); end
        n_checks++;
        if (second - first !== 32) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected 32", second - first); end
        idle_in();
        repeat (4) tick();
    endtask

    task automatic test_reset_busy();
        int bad = 0;
        idle_in();
        hif0.EX_DIV_START = 1'b1;
        tick();
        hif0.EX_DIV_START = 1'b0;
        repeat (9) tick();
        n_checks++;
        if (hif0.PC_HOLD !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got %b expected 1", hif0.PC_HOLD); end
        hif0.EX_RD = 5'd3; hif0.EX_WE = 1'b1; hif0.EX_MEMREAD = 1'b1;
        hif0.ID_RS1 = 5'd3; hif0.ID_RS1_USED = 1'b1;
        #1;
        RESET = 1'b0;
        #1;
        n_checks++;
        if (o0 !== 10'd0 || o1 !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_busy_async: got %b/%b expected all zero", o0, o1);
        end
        tick();
        idle_in();
        RESET = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (hif0.MULDIV_DONE || hif0.PC_HOLD || hif0.MEM_FORWARD_EN != 2'b00) bad++;
            tick();
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL rst_busy_after: got %0d active cycles expected 0", bad); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_ex_forward();
        test_load_use();
        test_random_forward();
        test_muldiv("div", 1'b0, 1'b1, 32, 32, 2, 2);
        test_muldiv("mul", 1'b1, 1'b0, 1, 1, 1, 0);
        test_muldiv("muldiv", 1'b1, 1'b1, 32, 32, 2, 2);
        test_back_to_back();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
